// File: rtl/bsk_bus_master.sv
// BSK backplane bus initiator: one host request becomes a timed
// CS/address/strobe sequence; read data and board ID are captured.
module bsk_bus_master #(
    parameter int unsigned T_SETUP  = 2,
    parameter int unsigned T_STROBE = 3,
    parameter int unsigned T_HOLD   = 1,
    parameter logic [3:0]  CS_IDLE  = 4'hF,
    parameter logic [7:0]  PASSWORD = 8'hA6
) (
    input  logic        iClk,
    input  logic        iRes,
    input  logic        iReq,
    input  logic        iWrite,
    input  logic [1:0]  iAddr,
    input  logic [3:0]  iSel,
    input  logic [15:0] iWData,
    output logic        oBusy,
    output logic        oDone,
    output logic [15:0] oRData,
    output logic        oPwdOk,
    output logic [5:0]  oVersion,
    inout  tri   [15:0] bD,
    output logic        oRd,
    output logic        oWr,
    output logic [1:0]  oA,
    output logic [3:0]  oCS
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_t;

    localparam int CW = 8;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          write_q, write_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          drive_q, drive_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [1:0]    a_q, a_d;
    logic [3:0]    cs_q, cs_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          pwd_ok_q, pwd_ok_d;
    logic [5:0]    version_q, version_d;

    // Next state, phase counter, capture and registered bus outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        a_d       = a_q;
        cs_d      = cs_q;
        rdata_d   = rdata_q;
        pwd_ok_d  = pwd_ok_q;
        version_d = version_q;

        unique case (state_q)
            S_IDLE: begin
                if (iReq) begin
                    write_d = iWrite;
                    wdata_d = iWData;
                    a_d     = iAddr;
                    cs_d    = iSel;
                    cnt_d   = CW'(T_SETUP - 1);
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = CW'(T_STROBE - 1);
                    state_d = S_STROBE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_STROBE: begin
                if (cnt_q == '0) begin
                    cnt_d   = CW'(T_HOLD - 1);
                    state_d = S_HOLD;
                    if (!write_q) begin
                        rdata_d = bD;
                        if (a_q == 2'd3) begin
                            pwd_ok_d  = (bD[15:8] == PASSWORD);
                            version_d = bD[7:2];
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_DONE) begin
            a_d  = 2'd0;
            cs_d = CS_IDLE;
        end

        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        rd_d    = !((state_d == S_STROBE) && !write_d);
        wr_d    = !((state_d == S_STROBE) && write_d);
        drive_d = write_d && ((state_d == S_SETUP) ||
                              (state_d == S_STROBE) ||
                              (state_d == S_HOLD));
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge iClk) begin
        if (!iRes) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            drive_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_q      <= 1'b1;
            wr_q      <= 1'b1;
            a_q       <= 2'd0;
            cs_q      <= CS_IDLE;
            rdata_q   <= '0;
            pwd_ok_q  <= 1'b0;
            version_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            drive_q   <= drive_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            a_q       <= a_d;
            cs_q      <= cs_d;
            rdata_q   <= rdata_d;
            pwd_ok_q  <= pwd_ok_d;
            version_q <= version_d;
        end
    end

    assign bD       = drive_q ? wdata_q : {16{1'bz}};
    assign oBusy    = busy_q;
    assign oDone    = done_q;
    assign oRData   = rdata_q;
    assign oPwdOk   = pwd_ok_q;
    assign oVersion = version_q;
    assign oRd      = rd_q;
    assign oWr      = wr_q;
    assign oA       = a_q;
    assign oCS      = cs_q;

endmodule

// File: tb/tb_bsk_bus_master.sv
// Bench for bsk_bus_master: default-timing and 1/1/1-timing instances
// checked each cycle against a transaction-phase model.
module tb_bsk_bus_master;

    logic        iClk = 1'b0;
    logic        iRes = 1'b0;
    logic        iReq = 1'b0;
    logic        iWrite = 1'b0;
    logic [1:0]  iAddr = 2'd0;
    logic [3:0]  iSel = 4'd0;
    logic [15:0] iWData = 16'd0;
    logic [15:0] resp_data = 16'd0;

    int n_vec = 0;
    int n_err = 0;

    always #5 iClk = ~iClk;

    logic        busy0, done0, pwd0, rd0, wr0;
    logic [15:0] rdata0;
    logic [5:0]  ver0;
    logic [1:0]  a0;
    logic [3:0]  cs0;
    tri   [15:0] bd0;

    logic        busy1, done1, pwd1, rd1, wr1;
    logic [15:0] rdata1;
    logic [5:0]  ver1;
    logic [1:0]  a1;
    logic [3:0]  cs1;
    tri   [15:0] bd1;

    // responders drive the bus while their master's read strobe is low
    assign bd0 = rd0 ? 16'hzzzz : resp_data;
    assign bd1 = rd1 ? 16'hzzzz : resp_data;

    bsk_bus_master u_def (
        .iClk(iClk), .iRes(iRes), .iReq(iReq), .iWrite(iWrite),
        .iAddr(iAddr), .iSel(iSel), .iWData(iWData),
        .oBusy(busy0), .oDone(done0), .oRData(rdata0),
        .oPwdOk(pwd0), .oVersion(ver0), .bD(bd0),
        .oRd(rd0), .oWr(wr0), .oA(a0), .oCS(cs0)
    );

    bsk_bus_master #(.T_SETUP(1), .T_STROBE(1), .T_HOLD(1)) u_fast (
        .iClk(iClk), .iRes(iRes), .iReq(iReq), .iWrite(iWrite),
        .iAddr(iAddr), .iSel(iSel), .iWData(iWData),
        .oBusy(busy1), .oDone(done1), .oRData(rdata1),
        .oPwdOk(pwd1), .oVersion(ver1), .bD(bd1),
        .oRd(rd1), .oWr(wr1), .oA(a1), .oCS(cs1)
    );

    function automatic int ts(int i);
        return (i == 0) ? 2 : 1;
    endfunction
    function automatic int tst(int i);
        return (i == 0) ? 3 : 1;
    endfunction
    function automatic int len(int i);
        return ts(i) + tst(i) + 1 + 1;
    endfunction

    task automatic chk(string nm, int i, logic [15:0] got, logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d: got %h expected %h", nm, i, got, exp);
        end
    endtask

    // model: each instance is idle or k cycles past its accept edge
    bit          act [2];
    int          k [2];
    logic        m_w [2];
    logic [1:0]  m_a [2];
    logic [3:0]  m_s [2];
    logic [15:0] m_wd [2];
    logic [15:0] m_rd [2];
    logic        m_pw [2];
    logic [5:0]  m_v [2];
    bit          live = 1'b0;

    always @(posedge iClk) begin
        for (int i = 0; i < 2; i++) begin
            if (!iRes) begin
                act[i]  <= 1'b0;
                k[i]    <= 0;
                m_wd[i] <= 16'd0;
                m_rd[i] <= 16'd0;
                m_pw[i] <= 1'b0;
                m_v[i]  <= 6'd0;
            end else if (act[i]) begin
                k[i] <= k[i] + 1;
                if (k[i] + 1 == len(i)) act[i] <= 1'b0;
                if (k[i] + 1 == ts(i) + tst(i) && !m_w[i]) begin
                    m_rd[i] <= resp_data;
                    if (m_a[i] == 2'd3) begin
                        m_pw[i] <= (resp_data[15:8] == 8'hA6);
                        m_v[i]  <= resp_data[7:2];
                    end
                end
            end else if (iReq) begin
                act[i]  <= 1'b1;
                k[i]    <= 0;
                m_w[i]  <= iWrite;
                m_a[i]  <= iAddr;
                m_s[i]  <= iSel;
                m_wd[i] <= iWData;
            end
        end
        live <= 1'b1;
    end

    task automatic check_inst(int i, logic busy, logic done, logic rd,
                              logic wr, logic [1:0] a, logic [3:0] cs,
                              logic [15:0] rdata, logic pwd,
                              logic [5:0] ver, logic [15:0] bd);
        int   L;
        int   kk;
        bit   on;
        bit   strobe;
        bit   bus;
        logic e_rd;
        L      = len(i);
        kk     = k[i];
        on     = act[i];
        bus    = on && (kk < L - 1);
        strobe = on && (kk >= ts(i)) && (kk < ts(i) + tst(i));
        e_rd   = !(strobe && !m_w[i]);
        chk("busy", i, 16'(busy), 16'(on));
        chk("done", i, 16'(done), 16'(on && kk == L - 1));
        chk("rd", i, 16'(rd), 16'(e_rd));
        chk("wr", i, 16'(wr), 16'(!(strobe && m_w[i])));
        chk("addr", i, 16'(a), bus ? 16'(m_a[i]) : 16'd0);
        chk("cs", i, 16'(cs), bus ? 16'(m_s[i]) : 16'hF);
        chk("rdata", i, rdata, m_rd[i]);
        chk("pwd_ok", i, 16'(pwd), 16'(m_pw[i]));
        chk("version", i, 16'(ver), 16'(m_v[i]));
        if (bus && m_w[i]) begin
            chk("bus_drive", i, 16'(bd === m_wd[i]), 16'd1);
        end else if (e_rd && m_wd[i] != 16'd0) begin
            chk("bus_release", i, 16'(bd === m_wd[i]), 16'd0);
        end
    endtask

    // compare both instances against the model every cycle
    always @(negedge iClk) begin
        if (live) begin
            check_inst(0, busy0, done0, rd0, wr0, a0, cs0,
                       rdata0, pwd0, ver0, bd0);
            check_inst(1, busy1, done1, rd1, wr1, a1, cs1,
                       rdata1, pwd1, ver1, bd1);
        end
    end

    task automatic start(input logic w, input logic [1:0] ad,
                         input logic [3:0] s, input logic [15:0] wd);
        @(posedge iClk);
        #2;
        iReq   = 1'b1;
        iWrite = w;
        iAddr  = ad;
        iSel   = s;
        iWData = wd;
        @(posedge iClk);
        #2;
        iReq = 1'b0;
    endtask

    logic [7:0]  wr_l, rd_l, done_l, cs_l, busy_l, bd_l;
    logic [7:0]  rd1_l, done1_l, busy1_l;
    logic [15:0] r1_at1, r1_at2;
    int          nd0, nd1, ovl;

    initial begin
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        chk("rst_cs", 0, 16'(cs0), 16'hF);
        chk("rst_strobes", 0, 16'({rd0, wr0}), 16'h3);
        chk("rst_busy", 0, 16'({busy0, done0}), 16'h0);
        #2 iRes = 1'b1;
        repeat (2) @(posedge iClk);

        // write, default timing
        start(1'b1, 2'd0, 4'b0111, 16'h1234);
        for (int j = 0; j < 8; j++) begin
            @(negedge iClk);
            wr_l[j]   = wr0;
            rd_l[j]   = rd0;
            done_l[j] = done0;
            cs_l[j]   = (cs0 == 4'b0111);
            busy_l[j] = busy0;
            bd_l[j]   = (bd0 === 16'h1234);
        end
        chk("wr_window", 0, 16'(wr_l), 16'h00E3);
        chk("rd_idle", 0, 16'(rd_l), 16'h00FF);
        chk("done_cycle", 0, 16'(done_l), 16'h0040);
        chk("cs_window", 0, 16'(cs_l), 16'h003F);
        chk("busy_window", 0, 16'(busy_l), 16'h007F);
        chk("bus_window", 0, 16'(bd_l), 16'h003F);

        // ID read with the right password
        resp_data = 16'hA690;
        start(1'b0, 2'd3, 4'h5, 16'hBEEF);
        for (int j = 0; j < 8; j++) begin
            @(negedge iClk);
            rd1_l[j]   = rd1;
            done1_l[j] = done1;
            busy1_l[j] = busy1;
            if (j == 1) r1_at1 = rdata1;
            if (j == 2) r1_at2 = rdata1;
        end
        chk("id_rdata", 0, rdata0, 16'hA690);
        chk("id_pwd", 0, 16'(pwd0), 16'd1);
        chk("id_ver", 0, 16'(ver0), 16'h0024);
        chk("fast_rd", 1, 16'(rd1_l), 16'h00FD);
        chk("fast_done", 1, 16'(done1_l), 16'h0008);
        chk("fast_busy", 1, 16'(busy1_l), 16'h000F);
        chk("fast_pre", 1, r1_at1, 16'h0000);
        chk("fast_cap", 1, r1_at2, 16'hA690);

        // non-ID read leaves the ID flags alone
        resp_data = 16'h5555;
        start(1'b0, 2'd1, 4'h5, 16'hBEEF);
        repeat (8) @(negedge iClk);
        chk("r1_rdata", 0, rdata0, 16'h5555);
        chk("r1_pwd", 0, 16'(pwd0), 16'd1);
        chk("r1_ver", 0, 16'(ver0), 16'h0024);

        // ID read with the wrong password
        resp_data = 16'h5590;
        start(1'b0, 2'd3, 4'h5, 16'hBEEF);
        repeat (8) @(negedge iClk);
        chk("bad_rdata", 0, rdata0, 16'h5590);
        chk("bad_pwd", 0, 16'(pwd0), 16'd0);
        chk("bad_ver", 0, 16'(ver0), 16'h0024);

        // request held high: back-to-back writes
        @(posedge iClk);
        #2;
        iReq   = 1'b1;
        iWrite = 1'b1;
        iAddr  = 2'd1;
        iSel   = 4'd2;
        iWData = 16'hC0DE;
        nd0 = 0;
        nd1 = 0;
        ovl = 0;
        @(posedge iClk);
        for (int j = 0; j < 24; j++) begin
            @(negedge iClk);
            if (done0) nd0++;
            if (done1) nd1++;
            if (!rd0 && !wr0) ovl++;
        end
        iReq = 1'b0;
        chk("stream_dones", 0, 16'(nd0), 16'd3);
        chk("stream_dones", 1, 16'(nd1), 16'd5);
        chk("stream_overlap", 0, 16'(ovl), 16'd0);
        repeat (10) @(negedge iClk);

        // reset in the middle of a write strobe
        start(1'b1, 2'd2, 4'h3, 16'hA5A5);
        repeat (3) @(negedge iClk);
        chk("pre_rst_wr", 0, 16'(wr0), 16'd0);
        iRes = 1'b0;
        @(negedge iClk);
        chk("rst_wr", 0, 16'(wr0), 16'd1);
        chk("rst_cs_mid", 0, 16'(cs0), 16'hF);
        chk("rst_busy_mid", 0, 16'(busy0), 16'd0);
        chk("rst_bus", 0, 16'(bd0 === 16'hA5A5), 16'd0);
        chk("rst_rdata", 0, rdata0, 16'd0);
        chk("rst_pwd", 0, 16'(pwd0), 16'd0);
        iRes = 1'b1;
        nd0 = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge iClk);
            if (done0) nd0++;
        end
        chk("rst_no_done", 0, 16'(nd0), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
